// File: rtl/gol_board_controller.sv
// 8x8 Game of Life board controller: owns the board register, paces generations and
// hands each one to an external engine. Optional still-life detection: GOL_STABLE_DETECT_EN.
module gol_board_controller #(
  parameter int unsigned TICK_DIV    = 1_000_000,
  parameter int unsigned GEN_W       = 16,
  parameter logic [63:0] RESET_BOARD = 64'h0000_0000_0007_0402
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             seed_valid_i,
  input  logic [63:0]      seed_bits_i,
  output logic             seed_ready_o,
  input  logic             run_i,
  input  logic             step_i,
  input  logic [63:0]      next_bits_i,
  output logic             update_o,
  output logic [63:0]      current_bits_o,
  output logic [GEN_W-1:0] gen_count_o,
  output logic             busy_o,
  output logic             stable_o
);

  localparam int unsigned PreW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [63:0]       board_q, board_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic              stable_q, stable_d;
  logic              update_q, update_d;
  logic              idle, seed_hs, tick, adv;

  assign idle    = (state_q == StIdle);
  assign seed_hs = seed_valid_i & idle;
  assign tick    = run_i & (pre_q == PreW'(TICK_DIV - 1));
  // A seed handshake wins over a coincident advance; that advance is dropped.
  assign adv     = idle & ~seed_hs & ~stable_q & (run_i ? tick : step_i);

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    pre_d    = pre_q + PreW'(1);
    if (!run_i || seed_hs || tick) begin
      pre_d = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (seed_hs) begin
          board_d  = seed_bits_i;
          gen_d    = '0;
          stable_d = 1'b0;
        end else if (adv) begin
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        board_d = next_bits_i;
        state_d = StIdle;
`ifdef GOL_STABLE_DETECT_EN
        if (next_bits_i == board_q) begin
          stable_d = 1'b1;
        end else begin
          gen_d = gen_q + GEN_W'(1);
        end
`else
        gen_d = gen_q + GEN_W'(1);
`endif
      end
      default: state_d = StIdle;
    endcase

    update_d = (state_d == StIssue);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      board_q  <= RESET_BOARD;
      gen_q    <= '0;
      pre_q    <= '0;
      stable_q <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      gen_q    <= gen_d;
      pre_q    <= pre_d;
      stable_q <= stable_d;
      update_q <= update_d;
    end
  end

  assign seed_ready_o   = idle;
  assign update_o       = update_q;
  assign current_bits_o = board_q;
  assign gen_count_o    = gen_q;
  assign busy_o         = ~idle;
  assign stable_o       = stable_q;

endmodule

// File: tb/tb_gol_board_controller.sv
// Scoreboard bench for gol_board_controller with a toroidal Life engine model.
module tb_gol_board_controller;
  localparam int unsigned TickDiv    = 4;
  localparam int unsigned GenW       = 4;
  localparam logic [63:0] ResetBoard = 64'h0000_0000_0007_0402;

  logic            clk = 1'b0;
  logic            rst;
  logic            seed_valid;
  logic [63:0]     seed_bits;
  logic            seed_ready;
  logic            run;
  logic            step;
  logic [63:0]     next_bits = '0;
  logic            update;
  logic [63:0]     current_bits;
  logic [GenW-1:0] gen_count;
  logic            busy;
  logic            stable;

  always #5 clk = ~clk;

  gol_board_controller #(
    .TICK_DIV    (TickDiv),
    .GEN_W       (GenW),
    .RESET_BOARD (ResetBoard)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .seed_valid_i   (seed_valid),
    .seed_bits_i    (seed_bits),
    .seed_ready_o   (seed_ready),
    .run_i          (run),
    .step_i         (step),
    .next_bits_i    (next_bits),
    .update_o       (update),
    .current_bits_o (current_bits),
    .gen_count_o    (gen_count),
    .busy_o         (busy),
    .stable_o       (stable)
  );

  typedef struct {
    logic [63:0]     board;
    logic [GenW-1:0] gen;
  } exp_t;

  exp_t        exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] m_board;
  int          m_gen;
  bit          m_stable;

  // Conway's rules on an 8x8 torus.
  function automatic logic [63:0] life(input logic [63:0] b);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              cnt += int'(b[((r + dr + 8) % 8) * 8 + ((c + dc + 8) % 8)]);
            end
          end
        end
        n[r * 8 + c] = (cnt == 3) || (b[r * 8 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // Registered engine: result valid the cycle after update.
  always @(posedge clk) begin
    if (update) next_bits <= life(current_bits);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && update) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_update: got board %h want no update", current_bits);
      end else begin
        e = exp_q.pop_front();
        chk("upd_board", current_bits, e.board);
        chk("upd_gen", 64'(gen_count), 64'(e.gen));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_seed(input logic [63:0] b);
    m_board  = b;
    m_gen    = 0;
    m_stable = 0;
  endtask

  task automatic model_adv();
    logic [63:0] nb;
    if (!m_stable) begin
      exp_q.push_back('{m_board, GenW'(m_gen)});
      nb = life(m_board);
`ifdef GOL_STABLE_DETECT_EN
      if (nb == m_board) m_stable = 1;
      else m_gen = (m_gen + 1) % (1 << GenW);
`else
      m_gen = (m_gen + 1) % (1 << GenW);
`endif
      m_board = nb;
    end
  endtask

  task automatic do_seed(input logic [63:0] b);
    seed_valid = 1'b1;
    seed_bits  = b;
    cyc();
    seed_valid = 1'b0;
    model_seed(b);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_board"}, current_bits, m_board);
    chk({tag, "_gen"}, 64'(gen_count), 64'(m_gen));
    chk({tag, "_stable"}, 64'(stable), 64'(m_stable));
  endtask

  initial begin
    int ups;
    int last;
    rst = 1'b1; seed_valid = 1'b0; seed_bits = '0; run = 1'b0; step = 1'b0;
    repeat (2) cyc();
    chk("rst_board", current_bits, ResetBoard);
    chk("rst_gen", 64'(gen_count), 64'(0));
    chk("rst_update", 64'(update), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(seed_ready), 64'(1));
    chk("rst_stable", 64'(stable), 64'(0));
    rst = 1'b0;
    model_seed(ResetBoard);

    // Free run: one update every TickDiv cycles.
    run = 1'b1; ups = 0; last = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i % TickDiv == 0) model_adv();
      cyc();
      if (update) begin
        ups++;
        if (last >= 0) chk("run_interval", 64'(i - last), 64'(TickDiv));
        last = i;
      end
    end
    run = 1'b0;
    repeat (3) cyc();
    chk("run_updates", 64'(ups), 64'(10));
    chk_state("run");

    // Single step latency.
    do_seed(64'h0200_0000_0000_0202);
    step = 1'b1;
    model_adv();
    chk("step_upd_n", 64'(update), 64'(0));
    cyc();
    step = 1'b0;
    chk("step_upd_n1", 64'(update), 64'(1));
    chk("step_busy_n1", 64'(busy), 64'(1));
    chk("step_ready_n1", 64'(seed_ready), 64'(0));
    cyc();
    chk("step_upd_n2", 64'(update), 64'(0));
    chk("step_board_n2", current_bits, 64'h0200_0000_0000_0202);
    cyc();
    chk("step_busy_n3", 64'(busy), 64'(0));
    chk_state("step");

    // Seed coincident with a tick: seed wins, tick dropped, prescaler restarts.
    run = 1'b1;
    repeat (TickDiv - 1) cyc();
    seed_valid = 1'b1;
    seed_bits  = 64'h0000_0000_0002_0306;
    cyc();
    seed_valid = 1'b0;
    model_seed(64'h0000_0000_0002_0306);
    chk("seedtick_upd", 64'(update), 64'(0));
    chk_state("seedtick");
    for (int k = 1; k <= TickDiv; k++) begin
      if (k == TickDiv) model_adv();
      cyc();
      chk("seedtick_next", 64'(update), 64'(k == TickDiv));
    end
    run = 1'b0;
    repeat (2) cyc();
    chk_state("seedtick_done");

    // Still life block under free run.
    do_seed(64'h0000_0000_0000_0303);
    chk_state("block_seed");
    run = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i % TickDiv == 0) model_adv();
      cyc();
    end
    run = 1'b0;
    repeat (3) cyc();
    chk_state("block");
    chk("block_queue", 64'(exp_q.size()), 64'(0));
    do_seed(64'h0000_0000_0000_0303);
    chk_state("block_reseed");

    // Reset during WAIT aborts the pending result.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_seed(ResetBoard);
    step = 1'b1;
    model_adv();
    cyc();
    step = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_seed(ResetBoard);
    chk_state("abort");
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_update", 64'(update), 64'(0));
    cyc();
    chk("abort_hold", current_bits, ResetBoard);

    // Random seeds and steps; stray steps while busy must be ignored.
    for (int it = 0; it < 24; it++) begin
      do_seed({$urandom, $urandom});
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        step = 1'b1;
        model_adv();
        cyc();
        step = 1'($urandom_range(0, 1));
        cyc();
        step = 1'($urandom_range(0, 1));
        cyc();
        step = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
      end
      chk_state("rand");
    end

    cyc();
    chk("final_queue", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
